sparc_decode_stage: RTL and testbench

Parametrised, pipelined SPARC integer decode stage between fetch and execute. It accepts one instruction per cycle over a valid/ready handshake and reads operands from the external register file. It emits a registered control/operand bundle and resolves branches against an internal ICC register. ICC hazards are interlocked by counting in-flight condition-code writers.

---
 rtl/sparc_decode_stage_if.sv | 46 ++++
 rtl/sparc_decode_stage.sv | 254 +++++++++++++++++++++++++
 tb/tb_sparc_decode_stage.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sparc_decode_stage_if.sv
// Fetch-to-decode-to-execute handshake and decoded bundle signals.
// master = surrounding pipeline (fetch + execute), slave = the decode stage.
interface sparc_decode_stage_if #(
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       instruction;
    logic [DATA_W-1:0] pc;

    logic              out_valid;
    logic              out_ready;
    logic              mem_read;
    logic              mem_write;
    logic              reg_write;
    logic              mem_access_signed;
    logic              signed_mul;
    logic              left_shift;
    logic              arith_shift;
    logic              icc_set;
    logic              branch_taken;
    logic              illegal;
    logic [1:0]        mem_access_size;
    logic [2:0]        alu_op;
    logic [DATA_W-1:0] src_a;
    logic [DATA_W-1:0] src_b;
    logic [DATA_W-1:0] src_c;
    logic [4:0]        rd;
    logic [DATA_W-1:0] branch_target;

    modport master (
        output in_valid, instruction, pc, out_ready,
        input  in_ready, out_valid, mem_read, mem_write, reg_write,
               mem_access_signed, signed_mul, left_shift, arith_shift,
               icc_set, branch_taken, illegal, mem_access_size, alu_op,
               src_a, src_b, src_c, rd, branch_target
    );

    modport slave (
        input  in_valid, instruction, pc, out_ready,
        output in_ready, out_valid, mem_read, mem_write, reg_write,
               mem_access_signed, signed_mul, left_shift, arith_shift,
               icc_set, branch_taken, illegal, mem_access_size, alu_op,
               src_a, src_b, src_c, rd, branch_target
    );
endinterface

// File: rtl/sparc_decode_stage.sv
// SPARC integer decode stage with ICC branch resolution; DECODE_FULL_BCC_EN enables all 16 Bicc conditions.
// Latency: 1 cycle from accept to out_valid; bundle registered.
// Backpressure: holds bundle while !out_ready; in_ready drops on ICC interlock, flush, reset or full output.
module sparc_decode_stage #(
    parameter int DATA_W          = 32,
    parameter int MAX_CC_INFLIGHT = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    sparc_decode_stage_if.slave    bus,
    output logic [4:0]             rf_raddr_a,
    output logic [4:0]             rf_raddr_b,
    output logic [4:0]             rf_raddr_c,
    input  logic [DATA_W-1:0]      rf_rdata_a,
    input  logic [DATA_W-1:0]      rf_rdata_b,
    input  logic [DATA_W-1:0]      rf_rdata_c,
    input  logic                   icc_we,
    input  logic [3:0]             icc_nzvc,
    input  logic                   flush
);
    localparam logic [2:0] ALU_AND   = 3'd0;
    localparam logic [2:0] ALU_OR    = 3'd1;
    localparam logic [2:0] ALU_ADD   = 3'd2;
    localparam logic [2:0] ALU_SUB   = 3'd3;
    localparam logic [2:0] ALU_MUL   = 3'd4;
    localparam logic [2:0] ALU_DIV   = 3'd5;
    localparam logic [2:0] ALU_SHIFT = 3'd6;
    localparam logic [2:0] ALU_PASS  = 3'd7;
    localparam logic [3:0] CC_MAX    = 4'(MAX_CC_INFLIGHT);

    typedef struct packed {
        logic              mem_read;
        logic              mem_write;
        logic              reg_write;
        logic              mem_access_signed;
        logic              signed_mul;
        logic              left_shift;
        logic              arith_shift;
        logic              icc_set;
        logic              branch_taken;
        logic              illegal;
        logic [1:0]        mem_access_size;
        logic [2:0]        alu_op;
        logic [DATA_W-1:0] src_a;
        logic [DATA_W-1:0] src_b;
        logic [DATA_W-1:0] src_c;
        logic [4:0]        rd;
        logic [DATA_W-1:0] branch_target;
    } bundle_t;

    logic [31:0]       ins;
    logic [1:0]        op;
    logic [2:0]        op2;
    logic [5:0]        op3;
    logic [3:0]        cond;
    logic [DATA_W-1:0] simm;
    logic [DATA_W-1:0] opnd_b;
    logic [DATA_W-1:0] disp;

    bundle_t    dec;
    bundle_t    out_q;
    logic       out_vld_q;
    logic [3:0] cc_cnt;
    logic [3:0] icc_q;
    logic [3:0] cc_src;
    logic       cond_base;
    logic       cond_ok;
    logic       cond_legal;
    logic       cond_br;
    logic       stall;
    logic       in_rdy;
    logic       accept;
    logic       cc_inc;
    logic       cc_dec;

    assign ins    = bus.instruction;
    assign op     = ins[31:30];
    assign op2    = ins[24:22];
    assign op3    = ins[24:19];
    assign cond   = ins[28:25];
    assign simm   = DATA_W'($signed(ins[12:0]));
    assign opnd_b = ins[13] ? simm : rf_rdata_b;
    assign disp   = DATA_W'($signed({ins[21:0], 2'b00}));

    assign rf_raddr_a = ins[18:14];
    assign rf_raddr_b = ins[4:0];
    assign rf_raddr_c = ins[29:25];

    // The sole outstanding writer retiring this cycle supplies the flags directly.
    assign cc_src = (cc_cnt == 4'd1 && icc_we) ? icc_nzvc : icc_q;

    always_comb begin
        cond_base = 1'b0;
        case (cond[2:0])
            3'b000: cond_base = 1'b0;
            3'b001: cond_base = cc_src[2];
            3'b010: cond_base = cc_src[2] | (cc_src[3] ^ cc_src[1]);
            3'b011: cond_base = cc_src[3] ^ cc_src[1];
            3'b100: cond_base = cc_src[0] | cc_src[2];
            3'b101: cond_base = cc_src[0];
            3'b110: cond_base = cc_src[3];
            3'b111: cond_base = cc_src[1];
            default: cond_base = 1'b0;
        endcase
        cond_ok = cond_base ^ cond[3];
`ifdef DECODE_FULL_BCC_EN
        cond_legal = 1'b1;
`else
        case (cond)
            4'b1000, 4'b0000, 4'b0001, 4'b1001, 4'b0110, 4'b1110: cond_legal = 1'b1;
            default: cond_legal = 1'b0;
        endcase
`endif
    end

    always_comb begin
        dec     = '0;
        cond_br = 1'b0;
        case (op)
            2'b11: begin
                case (op3)
                    6'b000000, 6'b000001, 6'b000010, 6'b000011, 6'b001001, 6'b001010: begin
                        dec.mem_read          = 1'b1;
                        dec.reg_write         = 1'b1;
                        dec.rd                = ins[29:25];
                        dec.mem_access_signed = op3[3];
                    end
                    6'b000100, 6'b000101, 6'b000110, 6'b000111: begin
                        dec.mem_write = 1'b1;
                        dec.src_c     = rf_rdata_c;
                    end
                    default: dec.illegal = 1'b1;
                endcase
                if (!dec.illegal) begin
                    dec.alu_op = ALU_ADD;
                    dec.src_a  = rf_rdata_a;
                    dec.src_b  = opnd_b;
                    case (op3[1:0])
                        2'b00:   dec.mem_access_size = 2'b10;
                        2'b01:   dec.mem_access_size = 2'b00;
                        2'b10:   dec.mem_access_size = 2'b01;
                        default: dec.mem_access_size = 2'b11;
                    endcase
                end
            end
            2'b10: begin
                case (op3)
                    6'b000000, 6'b010000: dec.alu_op = ALU_ADD;
                    6'b000001, 6'b010001: dec.alu_op = ALU_AND;
                    6'b000010, 6'b010010: dec.alu_op = ALU_OR;
                    6'b000100, 6'b010100: dec.alu_op = ALU_SUB;
                    6'b001010, 6'b011010: dec.alu_op = ALU_MUL;
                    6'b001011, 6'b011011: begin
                        dec.alu_op     = ALU_MUL;
                        dec.signed_mul = 1'b1;
                    end
                    6'b001110, 6'b011110: dec.alu_op = ALU_DIV;
                    6'b100101: begin
                        dec.alu_op     = ALU_SHIFT;
                        dec.left_shift = 1'b1;
                    end
                    6'b100110: dec.alu_op = ALU_SHIFT;
                    6'b100111: begin
                        dec.alu_op      = ALU_SHIFT;
                        dec.arith_shift = 1'b1;
                    end
                    default: dec.illegal = 1'b1;
                endcase
                if (dec.illegal) begin
                    dec.alu_op      = ALU_AND;
                    dec.signed_mul  = 1'b0;
                    dec.left_shift  = 1'b0;
                    dec.arith_shift = 1'b0;
                end else begin
                    dec.reg_write = 1'b1;
                    dec.icc_set   = op3[4];
                    dec.rd        = ins[29:25];
                    dec.src_a     = rf_rdata_a;
                    dec.src_b     = opnd_b;
                end
            end
            2'b00: begin
                if (op2 == 3'b100) begin
                    dec.reg_write = 1'b1;
                    dec.alu_op    = ALU_PASS;
                    dec.rd        = ins[29:25];
                    dec.src_b     = DATA_W'({ins[21:0], 10'b0});
                end else if (op2 == 3'b010 && cond_legal) begin
                    cond_br           = (cond[2:0] != 3'b000);
                    dec.branch_taken  = cond_ok;
                    dec.branch_target = bus.pc + disp;
                end else begin
                    dec.illegal = 1'b1;
                end
            end
            default: dec.illegal = 1'b1;
        endcase
    end

    assign stall = bus.in_valid &&
                   ((cond_br && cc_cnt != 4'd0 && !(cc_cnt == 4'd1 && icc_we)) ||
                    (dec.icc_set && cc_cnt == CC_MAX && !icc_we));
    assign in_rdy = rst_n && !flush && !stall && (!out_vld_q || bus.out_ready);
    assign accept = bus.in_valid && in_rdy;
    assign cc_inc = accept && dec.icc_set;
    assign cc_dec = icc_we && cc_cnt != 4'd0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_vld_q <= 1'b0;
            out_q     <= '0;
            cc_cnt    <= 4'd0;
            icc_q     <= 4'd0;
        end else begin
            if (icc_we)
                icc_q <= icc_nzvc;
            if (flush) begin
                out_vld_q <= 1'b0;
                cc_cnt    <= 4'd0;
            end else begin
                if (accept) begin
                    out_vld_q <= 1'b1;
                    out_q     <= dec;
                end else if (bus.out_ready) begin
                    out_vld_q <= 1'b0;
                end
                if (cc_inc && !cc_dec)
                    cc_cnt <= cc_cnt + 4'd1;
                else if (!cc_inc && cc_dec)
                    cc_cnt <= cc_cnt - 4'd1;
            end
        end
    end

    assign bus.in_ready          = in_rdy;
    assign bus.out_valid         = out_vld_q;
    assign bus.mem_read          = out_q.mem_read;
    assign bus.mem_write         = out_q.mem_write;
    assign bus.reg_write         = out_q.reg_write;
    assign bus.mem_access_signed = out_q.mem_access_signed;
    assign bus.signed_mul        = out_q.signed_mul;
    assign bus.left_shift        = out_q.left_shift;
    assign bus.arith_shift       = out_q.arith_shift;
    assign bus.icc_set           = out_q.icc_set;
    assign bus.branch_taken      = out_q.branch_taken;
    assign bus.illegal           = out_q.illegal;
    assign bus.mem_access_size   = out_q.mem_access_size;
    assign bus.alu_op            = out_q.alu_op;
    assign bus.src_a             = out_q.src_a;
    assign bus.src_b             = out_q.src_b;
    assign bus.src_c             = out_q.src_c;
    assign bus.rd                = out_q.rd;
    assign bus.branch_target     = out_q.branch_target;
endmodule

// File: tb/tb_sparc_decode_stage.sv
// Directed bench for sparc_decode_stage: hand-encoded instructions with hand-computed bundles.
module tb_sparc_decode_stage;
    logic        clk;
    logic        rst_n;
    logic [4:0]  rf_raddr_a, rf_raddr_b, rf_raddr_c;
    logic [31:0] rf_rdata_a, rf_rdata_b, rf_rdata_c;
    logic        icc_we;
    logic [3:0]  icc_nzvc;
    logic        flush;
    logic [31:0] rf [32];
    int          tests_run;
    int          tests_failed;
    int          waited;

    sparc_decode_stage_if #(.DATA_W(32)) bus ();

    sparc_decode_stage #(.DATA_W(32), .MAX_CC_INFLIGHT(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .rf_raddr_a (rf_raddr_a),
        .rf_raddr_b (rf_raddr_b),
        .rf_raddr_c (rf_raddr_c),
        .rf_rdata_a (rf_rdata_a),
        .rf_rdata_b (rf_rdata_b),
        .rf_rdata_c (rf_rdata_c),
        .icc_we     (icc_we),
        .icc_nzvc   (icc_nzvc),
        .flush      (flush)
    );

    assign rf_rdata_a = rf[rf_raddr_a];
    assign rf_rdata_b = rf[rf_raddr_b];
    assign rf_rdata_c = rf[rf_raddr_c];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] f3(input logic [1:0] op, input logic [4:0] rd,
                                       input logic [5:0] op3, input logic [4:0] rs1,
                                       input logic i, input logic [12:0] lo);
        return {op, rd, op3, rs1, i, lo};
    endfunction

    function automatic logic [31:0] bicc(input logic [3:0] cond, input logic [21:0] disp);
        return {2'b00, 1'b0, cond, 3'b010, disp};
    endfunction

    // Starts and ends just after a falling edge; returns cycles spent stalled.
    task automatic send(input logic [31:0] ins, input logic [31:0] p, input int budget,
                        output int w);
        w = 0;
        bus.in_valid    = 1'b1;
        bus.instruction = ins;
        bus.pc          = p;
        #1;
        while (!bus.in_ready && w < budget) begin
            @(negedge clk);
            #1;
            w++;
        end
        if (!bus.in_ready) begin
            chk("accept_timeout", {31'd0, bus.in_ready}, 32'd1);
            @(negedge clk);
        end else begin
            @(posedge clk);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic icc_pulse(input logic [3:0] v);
        icc_we   = 1'b1;
        icc_nzvc = v;
        @(negedge clk);
        icc_we   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tests_run       = 0;
        tests_failed    = 0;
        rst_n           = 1'b0;
        bus.in_valid    = 1'b0;
        bus.instruction = 32'd0;
        bus.pc          = 32'd0;
        bus.out_ready   = 1'b0;
        icc_we          = 1'b0;
        icc_nzvc        = 4'd0;
        flush           = 1'b0;
        for (int i = 0; i < 32; i++) rf[i] = 32'h100 + i;
        rf[0] = 32'd0;
        rf[1] = 32'd5;
        rf[2] = 32'd7;

        repeat (3) @(negedge clk);
        bus.in_valid = 1'b1;
        #1;
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_bundle", {31'd0, |{bus.mem_read, bus.mem_write, bus.reg_write, bus.icc_set,
                                    bus.illegal, bus.alu_op, bus.src_a, bus.src_b, bus.rd}}, 32'd0);
        bus.in_valid  = 1'b0;
        @(negedge clk);
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;

        // add r3, r1, r2
        send(f3(2'b10, 5'd3, 6'b000000, 5'd1, 1'b0, 13'd2), 32'h0, 3, waited);
        chk("add_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("add_alu", {29'd0, bus.alu_op}, 32'd2);
        chk("add_src_a", bus.src_a, 32'd5);
        chk("add_src_b", bus.src_b, 32'd7);
        chk("add_rd", {27'd0, bus.rd}, 32'd3);
        chk("add_we", {31'd0, bus.reg_write}, 32'd1);

        // ldsh r4, [r1 - 4]
        send(f3(2'b11, 5'd4, 6'b001010, 5'd1, 1'b1, 13'h1FFC), 32'h4, 3, waited);
        chk("ldsh_rd", {31'd0, bus.mem_read}, 32'd1);
        chk("ldsh_size", {30'd0, bus.mem_access_size}, 32'd1);
        chk("ldsh_signed", {31'd0, bus.mem_access_signed}, 32'd1);
        chk("ldsh_src_b", bus.src_b, 32'hFFFF_FFFC);
        chk("ldsh_we", {31'd0, bus.reg_write}, 32'd1);

        // st r2, [r1 + 8]
        send(f3(2'b11, 5'd2, 6'b000100, 5'd1, 1'b1, 13'd8), 32'h8, 3, waited);
        chk("st_wr", {31'd0, bus.mem_write}, 32'd1);
        chk("st_src_c", bus.src_c, 32'd7);
        chk("st_size", {30'd0, bus.mem_access_size}, 32'd2);
        chk("st_we", {31'd0, bus.reg_write}, 32'd0);

        // subcc r5, r1, r2 then be +3 at 0x100
        send(f3(2'b10, 5'd5, 6'b010100, 5'd1, 1'b0, 13'd2), 32'hC, 3, waited);
        chk("subcc_icc_set", {31'd0, bus.icc_set}, 32'd1);
        chk("subcc_alu", {29'd0, bus.alu_op}, 32'd3);
        bus.in_valid    = 1'b1;
        bus.instruction = bicc(4'b0001, 22'd3);
        bus.pc          = 32'h100;
        #1;
        chk("be_stall0", {31'd0, bus.in_ready}, 32'd0);
        @(negedge clk);
        #1;
        chk("be_stall1", {31'd0, bus.in_ready}, 32'd0);
        icc_we   = 1'b1;
        icc_nzvc = 4'b0100;
        #1;
        chk("be_bypass_ready", {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        icc_we       = 1'b0;
        bus.in_valid = 1'b0;
        chk("be_taken", {31'd0, bus.branch_taken}, 32'd1);
        chk("be_target", bus.branch_target, 32'h10C);
        chk("be_we", {31'd0, bus.reg_write}, 32'd0);

        // addcc x4 against a limit of 3
        for (int k = 0; k < 3; k++) begin
            send(f3(2'b10, 5'd9, 6'b010000, 5'd1, 1'b0, 13'd2), 32'h20, 3, waited);
            chk("addcc_nostall", waited, 32'd0);
        end
        bus.in_valid    = 1'b1;
        bus.instruction = f3(2'b10, 5'd9, 6'b010000, 5'd1, 1'b0, 13'd2);
        #1;
        chk("addcc4_stall", {31'd0, bus.in_ready}, 32'd0);
        @(negedge clk);
        icc_we   = 1'b1;
        icc_nzvc = 4'b0100;
        #1;
        chk("addcc4_release", {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        icc_we = 1'b0;
        chk("addcc4_icc_set", {31'd0, bus.icc_set}, 32'd1);
        #1;
        chk("addcc5_cnt_held", {31'd0, bus.in_ready}, 32'd0);
        bus.in_valid = 1'b0;

        // drain to zero, extra write must not underflow the count
        repeat (4) icc_pulse(4'b0100);
        send(bicc(4'b1001, 22'd0), 32'h200, 3, waited);
        chk("bne_nostall", waited, 32'd0);
        chk("bne_taken", {31'd0, bus.branch_taken}, 32'd0);

        // output hold under backpressure
        send(f3(2'b10, 5'd7, 6'b000001, 5'd1, 1'b0, 13'd2), 32'h30, 3, waited);
        bus.out_ready   = 1'b0;
        bus.in_valid    = 1'b1;
        bus.instruction = f3(2'b10, 5'd8, 6'b000010, 5'd1, 1'b0, 13'd2);
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("hold_in_ready", {31'd0, bus.in_ready}, 32'd0);
            chk("hold_bundle", {24'd0, bus.out_valid, bus.alu_op, bus.rd}, {24'd0, 1'b1, 3'd0, 5'd7});
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        #1;
        chk("hold_release", {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("or_alu", {29'd0, bus.alu_op}, 32'd1);
        chk("or_rd", {27'd0, bus.rd}, 32'd8);

        // flush while a branch is interlocked
        send(f3(2'b10, 5'd5, 6'b010100, 5'd1, 1'b0, 13'd2), 32'h40, 3, waited);
        bus.out_ready   = 1'b0;
        bus.in_valid    = 1'b1;
        bus.instruction = bicc(4'b0001, 22'd3);
        bus.pc          = 32'h100;
        #1;
        chk("flush_pre_stall", {31'd0, bus.in_ready}, 32'd0);
        flush = 1'b1;
        #1;
        chk("flush_in_ready", {31'd0, bus.in_ready}, 32'd0);
        @(negedge clk);
        flush = 1'b0;
        chk("flush_out_valid", {31'd0, bus.out_valid}, 32'd0);
        bus.out_ready = 1'b1;
        #1;
        chk("flush_cnt_zero", {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("flush_icc_kept", {31'd0, bus.branch_taken}, 32'd1);

        // illegal op3
        send(f3(2'b10, 5'd1, 6'b111111, 5'd1, 1'b0, 13'd2), 32'h50, 3, waited);
        chk("ill_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("ill_flag", {31'd0, bus.illegal}, 32'd1);
        chk("ill_enables", {31'd0, |{bus.mem_read, bus.mem_write, bus.reg_write,
                                     bus.icc_set, bus.branch_taken}}, 32'd0);
        chk("ill_src_a", bus.src_a, 32'd0);

        // bvs with V=1, disp -1 at 0x300
        icc_pulse(4'b0010);
        send(bicc(4'b0111, 22'h3FFFFF), 32'h300, 3, waited);
        chk("bvs_nostall", waited, 32'd0);
`ifdef DECODE_FULL_BCC_EN
        chk("bvs_taken", {31'd0, bus.branch_taken}, 32'd1);
        chk("bvs_illegal", {31'd0, bus.illegal}, 32'd0);
        chk("bvs_target", bus.branch_target, 32'h2FC);
`else
        chk("bvs_taken", {31'd0, bus.branch_taken}, 32'd0);
        chk("bvs_illegal", {31'd0, bus.illegal}, 32'd1);
`endif

        // sethi %hi(0x12345<<10), r6
        send({2'b00, 5'd6, 3'b100, 22'h12345}, 32'h60, 3, waited);
        chk("sethi_src_b", bus.src_b, 32'h048D_1400);
        chk("sethi_alu", {29'd0, bus.alu_op}, 32'd7);
        chk("sethi_rd", {27'd0, bus.rd}, 32'd6);
        chk("sethi_we", {31'd0, bus.reg_write}, 32'd1);

        // reset with a held bundle
        send(f3(2'b10, 5'd3, 6'b000000, 5'd1, 1'b0, 13'd2), 32'h70, 3, waited);
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("mid_held", {31'd0, bus.out_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", {31'd0, bus.in_ready}, 32'd0);
        @(negedge clk);
        chk("mid_rst_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("mid_rst_src_a", bus.src_a, 32'd0);
        rst_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
